// File: rtl/ccip_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccip_if_pkg
// Description : CCI-P interface types used by the read-response path: the
//               cache-line data type and the c0 response-type encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ccip_if_pkg;

   localparam int CCIP_CLDATA_WIDTH = 512;

   typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;

   // c0 Rx response types
   typedef enum logic [3:0] {
      eRSP_RDLINE = 4'h0,
      eRSP_UMSG   = 4'h4
   } t_ccip_c0_rsp;

endpackage
`default_nettype wire

// File: rtl/hc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc_pkg
// Description : Shared types for the host-channel read path: reorder-buffer
//               FSM states, default tag width and the slot index type.
// Revision    : 1.0 - initial release
// ============================================================================
package hc_pkg;

   localparam int HC_RD_TAG_W = 6;

   typedef logic [HC_RD_TAG_W-1:0] t_rob_idx;

   typedef enum logic [1:0] {
      S_RR_IDLE = 2'd0,
      S_RR_RUN  = 2'd1,
      S_RR_DONE = 2'd2
   } t_rd_rsp_state;

endpackage
`default_nettype wire

// File: rtl/hc_rob_mem.sv
`default_nettype none
// ============================================================================
// Module      : hc_rob_mem
// Description : Simple dual-port line store for the read reorder buffer.
//               One write port, one synchronous read port with enable; the
//               read register holds its value until the next enabled read.
// Revision    : 1.0 - initial release
// ============================================================================
module hc_rob_mem #(
   parameter int TAG_W  = 6,
   parameter int DATA_W = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [TAG_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [TAG_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2**TAG_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Line storage write port (no reset so the array maps onto block RAM)
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register: loaded only on release so the presented line stays put
   // even if its slot is reallocated and rewritten while the core stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hc_rd_rsp_rob.sv
`default_nettype none
// ============================================================================
// Module      : hc_rd_rsp_rob
// Description : CCI-P c0 read-response reorder buffer. Hands out mdata tags
//               and credit to the read requestor, stores out-of-order lines
//               by tag and delivers them to the core in request order over a
//               valid/ready handshake. Raises done after total_size lines.
//               Optional statistics are enabled by defining
//               HC_RD_RSP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hc_rd_rsp_rob
   import ccip_if_pkg::*, hc_pkg::*;
#(
   parameter int TAG_W  = HC_RD_TAG_W,
   parameter int DATA_W = $bits(t_ccip_clData),
   parameter int SIZE_W = 42
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SIZE_W-1:0] total_size,
   input  logic              req_issue,
   output logic [15:0]       req_tag,
   output logic              req_credit,
   input  logic              rsp_valid,
   input  logic [3:0]        rsp_type,
   input  logic [15:0]       rsp_mdata,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              done,
   output logic              err_unexpected,
   output logic [31:0]       stat_rsp_cnt,
   output logic [TAG_W:0]    stat_max_occ
);

   localparam int DEPTH = 2**TAG_W;

   localparam logic [TAG_W:0]    c_occ_full = {1'b1, {TAG_W{1'b0}}};
   localparam logic [TAG_W:0]    c_occ_one  = {{TAG_W{1'b0}}, 1'b1};
   localparam logic [TAG_W-1:0]  c_ptr_one  = {{(TAG_W-1){1'b0}}, 1'b1};
   localparam logic [SIZE_W-1:0] c_cnt_one  = {{(SIZE_W-1){1'b0}}, 1'b1};

   t_rd_rsp_state     r_state;
   t_rd_rsp_state     w_state_nxt;
   logic [TAG_W-1:0]  r_wr_ptr;
   logic [TAG_W-1:0]  r_rd_ptr;
   logic [TAG_W:0]    r_occ;
   logic [SIZE_W-1:0] r_delivered;
   logic [DEPTH-1:0]  r_pending;
   logic [DEPTH-1:0]  r_filled;
   logic              r_out_valid;
   logic              r_err;

   logic              w_start_run;
   logic              w_credit;
   logic              w_done;
   logic              w_alloc;
   logic [TAG_W-1:0]  w_rsp_idx;
   logic              w_rsp_rd;
   logic              w_accept;
   logic              w_release;
   logic              w_fire;
   logic [DATA_W-1:0] w_mem_rdata;
   logic              w_unused_mdata;

   // Upper mdata bits are echoed by CCI-P but carry nothing for us
   assign w_unused_mdata = ^rsp_mdata[15:TAG_W];

   assign w_start_run = (r_state == S_RR_IDLE) && start;
   assign w_alloc     = req_issue && w_credit;
   assign w_rsp_idx   = rsp_mdata[TAG_W-1:0];
   assign w_rsp_rd    = rsp_valid && (rsp_type == eRSP_RDLINE);
   assign w_accept    = w_rsp_rd && r_pending[w_rsp_idx] && !r_filled[w_rsp_idx];
   // Head slot moves to the output register whenever that register is free
   // or being emptied this cycle; run entry takes priority over everything
   assign w_release   = !w_start_run && r_filled[r_rd_ptr] && (!r_out_valid || out_ready);
   assign w_fire      = r_out_valid && out_ready;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RR_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RR_IDLE: if (start)                       w_state_nxt = S_RR_RUN;
         S_RR_RUN:  if (r_delivered == total_size)   w_state_nxt = S_RR_DONE;
         S_RR_DONE: if (!start)                      w_state_nxt = S_RR_IDLE;
         default:                                    w_state_nxt = S_RR_IDLE;
      endcase
   end

   // FSM outputs: credit and done come straight from registered state
   always_comb begin
      w_done   = (r_state == S_RR_DONE);
      w_credit = (r_state == S_RR_RUN) && (r_occ < c_occ_full);
   end

   // Tag allocation, head pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (w_start_run) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_alloc) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_release) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_alloc, w_release})
            2'b10:   r_occ <= r_occ + c_occ_one;
            2'b01:   r_occ <= r_occ - c_occ_one;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Per-slot pending/filled flags; alloc, fill and release never hit the
   // same slot in one cycle (alloc needs an empty slot, fill needs !filled)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
         r_filled  <= '0;
      end else if (w_start_run) begin
         r_pending <= '0;
         r_filled  <= '0;
      end else begin
         if (w_alloc) begin
            r_pending[r_wr_ptr] <= 1'b1;
         end
         if (w_accept) begin
            r_filled[w_rsp_idx] <= 1'b1;
         end
         if (w_release) begin
            r_pending[r_rd_ptr] <= 1'b0;
            r_filled[r_rd_ptr]  <= 1'b0;
         end
      end
   end

   // Output valid, delivered-line count and sticky protocol error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_delivered <= '0;
         r_err       <= 1'b0;
      end else if (w_start_run) begin
         r_out_valid <= 1'b0;
         r_delivered <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_release) begin
            r_out_valid <= 1'b1;
         end else if (w_fire) begin
            r_out_valid <= 1'b0;
         end
         if (w_fire) begin
            r_delivered <= r_delivered + c_cnt_one;
         end
         if (w_rsp_rd && !w_accept) begin
            r_err <= 1'b1;
         end
      end
   end

   hc_rob_mem #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_rob_mem (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_accept),
      .i_waddr (w_rsp_idx),
      .i_wdata (rsp_data),
      .i_re    (w_release),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_mem_rdata)
   );

`ifdef HC_RD_RSP_STATS_EN
   logic [31:0]    r_stat_rsp_cnt;
   logic [TAG_W:0] r_stat_max_occ;

   // Accepted-response counter (saturating) and peak occupancy tracker
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_rsp_cnt <= '0;
         r_stat_max_occ <= '0;
      end else if (w_start_run) begin
         r_stat_rsp_cnt <= '0;
         r_stat_max_occ <= '0;
      end else begin
         if (w_accept && (r_stat_rsp_cnt != 32'hFFFF_FFFF)) begin
            r_stat_rsp_cnt <= r_stat_rsp_cnt + 32'd1;
         end
         if (r_occ > r_stat_max_occ) begin
            r_stat_max_occ <= r_occ;
         end
      end
   end

   assign stat_rsp_cnt = r_stat_rsp_cnt;
   assign stat_max_occ = r_stat_max_occ;
`else
   assign stat_rsp_cnt = '0;
   assign stat_max_occ = '0;
`endif

   assign req_tag        = {{(16-TAG_W){1'b0}}, r_wr_ptr};
   assign req_credit     = w_credit;
   assign out_valid      = r_out_valid;
   assign out_data       = w_mem_rdata;
   assign done           = w_done;
   assign err_unexpected = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hc_rd_rsp_rob.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc_rd_rsp_rob
// Description : Self-checking bench for hc_rd_rsp_rob. Every issued read
//               pushes its line onto an expected queue in request order; a
//               monitor pops and compares on each accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc_rd_rsp_rob;
   import ccip_if_pkg::*;

   localparam int TAG_W  = 6;
   localparam int DEPTH  = 64;
   localparam int DATA_W = 512;
   localparam int SIZE_W = 42;

   localparam logic [3:0] RSP_RD = eRSP_RDLINE;
   localparam logic [3:0] RSP_WR = 4'h1;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [SIZE_W-1:0] total_size;
   logic              req_issue;
   logic [15:0]       req_tag;
   logic              req_credit;
   logic              rsp_valid;
   logic [3:0]        rsp_type;
   logic [15:0]       rsp_mdata;
   logic [DATA_W-1:0] rsp_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              done;
   logic              err_unexpected;
   logic [31:0]       stat_rsp_cnt;
   logic [TAG_W:0]    stat_max_occ;

   hc_rd_rsp_rob #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .SIZE_W (SIZE_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .total_size     (total_size),
      .req_issue      (req_issue),
      .req_tag        (req_tag),
      .req_credit     (req_credit),
      .rsp_valid      (rsp_valid),
      .rsp_type       (rsp_type),
      .rsp_mdata      (rsp_mdata),
      .rsp_data       (rsp_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .done           (done),
      .err_unexpected (err_unexpected),
      .stat_rsp_cnt   (stat_rsp_cnt),
      .stat_max_occ   (stat_max_occ)
   );

   always #5 clk = ~clk;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                beats    = 0;
   int                next_tag = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] slot_data [DEPTH];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic check_d(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_line();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Scoreboard monitor: in-order data check plus hold check under stall
   logic              mon_hold = 1'b0;
   logic [DATA_W-1:0] mon_hold_d;
   always @(negedge clk) begin
      if (reset) begin
         mon_hold = 1'b0;
      end else begin
         if (mon_hold) begin
            check_v("hold_valid", 64'(out_valid), 64'd1);
            check_d("hold_data", out_data, mon_hold_d);
         end
         if (out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL beat_unexpected: got beat %0h, required no beat", out_data);
            end else begin
               check_d("beat_data", out_data, exp_q.pop_front());
            end
         end
         mon_hold   = out_valid && !out_ready;
         mon_hold_d = out_data;
      end
   end

   task automatic start_run(input int size);
      total_size = SIZE_W'(size);
      start      = 1'b1;
      next_tag   = 0;
      tick();
   endtask

   task automatic end_run();
      start = 1'b0;
      tick();
   endtask

   task automatic issue_n(input int n);
      logic [DATA_W-1:0] d;
      int wc;
      for (int i = 0; i < n; i++) begin
         wc = 0;
         if (!req_credit) req_issue = 1'b0;
         while (!req_credit && wc < 100) begin
            tick();
            wc++;
         end
         if (!req_credit) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_credit_timeout: req_credit=%0b after %0d cycles, required 1", req_credit, wc);
            break;
         end
         check_v("req_tag", 64'(req_tag), 64'(next_tag));
         d = rand_line();
         slot_data[next_tag] = d;
         exp_q.push_back(d);
         req_issue = 1'b1;
         tick();
         next_tag = (next_tag + 1) % DEPTH;
      end
      req_issue = 1'b0;
   endtask

   task automatic respond(input int tag, input logic [3:0] typ, input bit bogus);
      rsp_valid = 1'b1;
      rsp_type  = typ;
      rsp_mdata = {(16-TAG_W)'($urandom), TAG_W'(tag)};
      rsp_data  = bogus ? rand_line() : slot_data[tag];
      tick();
      rsp_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c;
      c = 0;
      while (!done && c < budget) begin
         tick();
         c++;
      end
      check_v("done_reached", 64'(done), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   int                b0;
   logic              ov0, ov1;
   logic [DATA_W-1:0] hd;
   int                order[$];
   int                unresp[$];
   int                issued;
   int                cyc;
   int                tmp;
   int                idx;

   initial begin
      reset = 1'b1; start = 1'b0; total_size = '0; req_issue = 1'b0;
      rsp_valid = 1'b0; rsp_type = '0; rsp_mdata = '0; rsp_data = '0; out_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check_v("rst_out_valid", 64'(out_valid), 64'd0);
      check_v("rst_done", 64'(done), 64'd0);
      check_v("rst_credit", 64'(req_credit), 64'd0);
      check_v("rst_err", 64'(err_unexpected), 64'd0);
      check_v("rst_req_tag", 64'(req_tag), 64'd0);
      check_d("rst_out_data", out_data, '0);
      check_v("rst_stat_cnt", 64'(stat_rsp_cnt), 64'd0);
      check_v("rst_stat_occ", 64'(stat_max_occ), 64'd0);
      reset = 1'b0;
      tick();

      // In-order responses, latency of the first beat
      start_run(4);
      check_v("credit_in_run", 64'(req_credit), 64'd1);
      issue_n(4);
      b0 = beats;
      respond(0, RSP_RD, 1'b0); ov0 = out_valid;
      respond(1, RSP_RD, 1'b0); ov1 = out_valid;
      respond(2, RSP_RD, 1'b0);
      respond(3, RSP_RD, 1'b0);
      check_v("latency_t1", 64'(ov0), 64'd0);
      check_v("latency_t2", 64'(ov1), 64'd1);
      wait_done(20);
      check_v("inorder_beats", 64'(beats - b0), 64'd4);
      end_run();
      check_v("done_cleared", 64'(done), 64'd0);

      // Reordered responses 3,1,2,0
      start_run(4);
      issue_n(4);
      b0 = beats;
      respond(3, RSP_RD, 1'b0);
      respond(1, RSP_RD, 1'b0);
      respond(2, RSP_RD, 1'b0);
      tick();
      check_v("reorder_wait_beats", 64'(beats - b0), 64'd0);
      check_v("reorder_wait_valid", 64'(out_valid), 64'd0);
      respond(0, RSP_RD, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         check_v("reorder_burst", 64'(out_valid), 64'd1);
         tick();
      end
      wait_done(20);
      check_v("reorder_beats", 64'(beats - b0), 64'd4);
      end_run();

      // Full / credit / tag wrap
      start_run(65);
      issue_n(64);
      check_v("credit_full", 64'(req_credit), 64'd0);
      req_issue = 1'b1;
      tick();
      req_issue = 1'b0;
      check_v("credit_full_ignored", 64'(req_credit), 64'd0);
      check_v("req_tag_wrapped", 64'(req_tag), 64'd0);
      respond(0, RSP_RD, 1'b0);
      check_v("credit_still_full", 64'(req_credit), 64'd0);
      tick();
      check_v("credit_returned", 64'(req_credit), 64'd1);
      issue_n(1);
      order.delete();
      for (int t = 1; t < DEPTH; t++) order.push_back(t);
      order.push_back(0);
      for (int i = order.size() - 1; i > 0; i--) begin
         idx = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[idx]; order[idx] = tmp;
      end
      foreach (order[i]) respond(order[i], RSP_RD, 1'b0);
      wait_done(200);
      check_v("full_drained", 64'(exp_q.size()), 64'd0);
      end_run();

      // Backpressure
      start_run(3);
      out_ready = 1'b0;
      issue_n(3);
      respond(0, RSP_RD, 1'b0);
      respond(1, RSP_RD, 1'b0);
      respond(2, RSP_RD, 1'b0);
      check_v("bp_valid", 64'(out_valid), 64'd1);
      hd = out_data;
      check_d("bp_head_data", hd, slot_data[0]);
      repeat (10) tick();
      check_d("bp_stable", out_data, hd);
      b0 = beats;
      out_ready = 1'b1;
      repeat (3) tick();
      check_v("bp_burst", 64'(beats - b0), 64'd3);
      check_v("bp_drained_valid", 64'(out_valid), 64'd0);
      wait_done(20);
      end_run();

      // Error cases
      start_run(2);
      issue_n(2);
      b0 = beats;
      respond(0, RSP_WR, 1'b1);
      check_v("err_wrtype", 64'(err_unexpected), 64'd0);
      respond(1, RSP_RD, 1'b0);
      respond(1, RSP_RD, 1'b1);
      check_v("err_dup_filled", 64'(err_unexpected), 64'd1);
      check_v("err_no_early_beat", 64'(beats - b0), 64'd0);
      respond(0, RSP_RD, 1'b0);
      repeat (4) tick();
      check_v("err_beats", 64'(beats - b0), 64'd2);
      respond(0, RSP_RD, 1'b1);
      repeat (3) tick();
      check_v("err_no_extra_beat", 64'(beats - b0), 64'd2);
      check_v("err_sticky", 64'(err_unexpected), 64'd1);
      wait_done(20);
      end_run();
      start_run(1);
      check_v("err_clear_on_start", 64'(err_unexpected), 64'd0);
      respond(5, RSP_RD, 1'b1);
      check_v("err_never_issued", 64'(err_unexpected), 64'd1);
      issue_n(1);
      respond(0, RSP_RD, 1'b0);
      wait_done(20);
      end_run();

      // Reset in the middle of a run
      start_run(20);
      issue_n(10);
      respond(2, RSP_RD, 1'b0);
      respond(5, RSP_RD, 1'b0);
      b0 = beats;
      start = 1'b0;
      reset = 1'b1;
      #1;
      check_v("midrst_out_valid", 64'(out_valid), 64'd0);
      check_v("midrst_credit", 64'(req_credit), 64'd0);
      check_v("midrst_req_tag", 64'(req_tag), 64'd0);
      check_v("midrst_done", 64'(done), 64'd0);
      check_d("midrst_out_data", out_data, '0);
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
      tick();
      respond(0, RSP_RD, 1'b1);
      repeat (5) tick();
      check_v("midrst_no_deliver", 64'(beats - b0), 64'd0);
      total_size = '0;
      start = 1'b1;
      tick();
      check_v("size0_run_cycle", 64'(done), 64'd0);
      tick();
      check_v("size0_done", 64'(done), 64'd1);
      end_run();

      // Randomized interleaving of issue, out-of-order responses and stalls
      start_run(150);
      unresp.delete();
      issued = 0;
      cyc = 0;
      while (!done && cyc < 4000) begin
         if (unresp.size() > 0 && $urandom_range(0, 2) != 0) begin
            idx = $urandom_range(0, unresp.size() - 1);
            tmp = unresp[idx];
            unresp.delete(idx);
            rsp_valid = 1'b1;
            rsp_type  = RSP_RD;
            rsp_mdata = {(16-TAG_W)'($urandom), TAG_W'(tmp)};
            rsp_data  = slot_data[tmp];
         end else begin
            rsp_valid = 1'b0;
         end
         if (req_credit && issued < 150 && $urandom_range(0, 1) == 1) begin
            check_v("rand_req_tag", 64'(req_tag), 64'(next_tag));
            slot_data[next_tag] = rand_line();
            exp_q.push_back(slot_data[next_tag]);
            unresp.push_back(next_tag);
            next_tag = (next_tag + 1) % DEPTH;
            issued++;
            req_issue = 1'b1;
         end else begin
            req_issue = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
      end
      rsp_valid = 1'b0;
      req_issue = 1'b0;
      out_ready = 1'b1;
      check_v("rand_done", 64'(done), 64'd1);
      check_v("rand_drained", 64'(exp_q.size()), 64'd0);
      end_run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
